// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues a request-to-send, then clocks a
// start/8-data/odd-parity/stop frame out on device clock falling edges,
// and finishes by checking the device ACK and waiting for the bus to idle.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a frame timeout counter.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [3:0] LAST_EDGE_IDX = 4'd10;

  // Synchronizer and edge-detect registers; idle bus level is high.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  state_e           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       frame_q, frame_d;
  logic             ack_q, ack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  // The timeout length only matters when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Two-flop synchronizers for the raw bus lines plus the previous clock level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of order.
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // Next-state, frame sequencing and registered line-drive decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    ack_d     = ack_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          // Frame bits 0..9: data LSB first, odd parity, stop.
          frame_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;  // start bit, held until the first device edge
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      S_REQ: begin
        bit_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          if (bit_q == LAST_EDGE_IDX) begin
            // 11th falling edge: the device is driving its ACK now.
            ack_d     = data_sync_q;
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~frame_q[bit_q];
            bit_d     = bit_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (ack_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    to_d = '0;
    if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      to_d = to_q + TO_W'(1);
      if (to_q == TO_LAST) begin
        // Timeout wins over any concurrent completion.
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b1;
      end
    end
`endif

    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      inh_cnt_q <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign tx_ready    = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// on wired-AND lines and a per-cycle transfer timeline model.
module tb_ps2_host_tx;

  localparam int INH  = 10000;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk    (ps2_clk_line),
    .ps2_data   (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected line frame as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Transfer timeline model: cycles counted from the accepting edge.
  logic rst_q;
  bit   model_active = 1'b0;
  int   since = 0;
  int   exp_outcome = 0;  // 0 = done expected, 1 = err expected
  int   n_done = 0;
  int   n_err = 0;
  int   last_end_since = 0;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (reset) begin
      model_active = 1'b0;
      check("ready_in_reset", tx_ready, 1'b0);
      if (rst_q === 1'b1) begin
        check("reset_clk_oe", ps2_clk_oe, 1'b0);
        check("reset_data_oe", ps2_data_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done_err", {done, err}, 2'b00);
      end
    end else begin
      check("done_err_exclusive", done & err, 1'b0);
      if (done) n_done++;
      if (err) n_err++;
      if (done || err) begin
        check("end_while_active", model_active, 1'b1);
        check("end_kind", {done, err}, (exp_outcome == 0) ? 2'b10 : 2'b01);
        last_end_since = since + 1;
        model_active = 1'b0;
      end
      if (model_active) begin
        since++;
        check("busy_active", busy, 1'b1);
        check("ready_active", tx_ready, 1'b0);
        check("clk_oe_timeline", ps2_clk_oe, (since <= INH + 1) ? 1'b1 : 1'b0);
        if (since <= INH + 2)
          check("data_oe_timeline", ps2_data_oe, (since > INH) ? 1'b1 : 1'b0);
      end else begin
        check("busy_idle", busy, 1'b0);
        check("ready_idle", tx_ready, 1'b1);
        check("lines_idle", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        if (tx_valid) begin
          model_active = 1'b1;
          since = 0;
        end
      end
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Device side: waits for request-to-send, clocks n_edges falling edges and
  // samples the line late in each low phase; ACKs before the 11th edge if asked.
  task automatic device_frame(input logic ack, input int n_edges, output logic [10:0] got);
    int guard;
    got = '0;
    guard = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < INH + 200) begin
      @(negedge clk);
      guard++;
    end
    check("req_seen", guard < INH + 200, 1'b1);
    got[0] = ps2_data_line;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) dev_data = ~ack;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) got[e] = ps2_data_line;
      dev_clk = 1'b1;
    end
    if (n_edges == 11) begin
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_end(input int base_done, input int base_err, input int expect_err,
                          input int bound);
    int cnt;
    cnt = 0;
    while (n_done == base_done && n_err == base_err && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    check("end_within_bound", cnt < bound, 1'b1);
    check("end_err_count", n_err - base_err, expect_err);
    check("end_done_count", n_done - base_done, 1 - expect_err);
  endtask

  task automatic measure_inhibit(output int cnt);
    int guard;
    cnt = 0;
    guard = 0;
    while (guard < INH + 100) begin
      @(negedge clk);
      guard++;
      if (ps2_data_oe) break;
      if (ps2_clk_oe) cnt++;
    end
  endtask

  initial begin
    logic [10:0] got, got2;
    int          bd, be, inh_cnt;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {ps2_clk_oe, ps2_data_oe, busy, done, err, tx_ready}, 6'b000000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1'b1);

    // 0xED with tx_valid held and data changed to 0x55 during the transfer.
    exp_outcome = 0;
    bd = n_done; be = n_err;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'hED;
    @(posedge clk); #1;
    tx_data  = 8'h55;
    device_frame(1'b1, 11, got);
    check("frame_ed_literal", got, 11'h7DA);
    check("frame_ed_model", got, model_frame(8'hED));
    wait_end(bd, be, 0, 500);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    bd = n_done; be = n_err;
    device_frame(1'b1, 11, got2);
    check("frame_55_literal", got2, 11'h6AA);
    check("frame_55_model", got2, model_frame(8'h55));
    wait_end(bd, be, 0, 500);

    // 0xF4: parity 0 and an exact inhibit length before the start bit.
    bd = n_done; be = n_err;
    start_tx(8'hF4);
    fork
      measure_inhibit(inh_cnt);
      device_frame(1'b1, 11, got);
    join
    check("inhibit_len", inh_cnt, 10000);
    check("frame_f4_literal", got, 11'h5E8);
    check("frame_f4_parity", got[9], 1'b0);
    wait_end(bd, be, 0, 500);
    repeat (50) @(negedge clk);
    check("f4_single_done", n_done - bd, 1);
    check("f4_no_err", n_err - be, 0);

    // NACK: device leaves data high at the 11th edge.
    exp_outcome = 1;
    bd = n_done; be = n_err;
    start_tx(8'h00);
    device_frame(1'b0, 11, got);
    check("frame_00_model", got, model_frame(8'h00));
    wait_end(bd, be, 1, 500);
    repeat (50) @(negedge clk);
    check("nack_no_done", n_done - bd, 0);
    check("nack_idle", {busy, tx_ready}, 2'b01);

    // Reset after the 5th falling edge: data bit 4 of 0xED (0) is being driven.
    exp_outcome = 0;
    bd = n_done; be = n_err;
    start_tx(8'hED);
    device_frame(1'b1, 5, got);
    check("mid_frame_data_oe", ps2_data_oe, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_reset_no_pulse", {n_done - bd, n_err - be}, 64'd0);

    // A normal 0xED transfer after that reset.
    start_tx(8'hED);
    device_frame(1'b1, 11, got);
    check("frame_ed_after_reset", got, 11'h7DA);
    wait_end(bd, be, 0, 500);

    // Silent device after the request.
    bd = n_done; be = n_err;
`ifdef PS2_TX_TIMEOUT_EN
    exp_outcome = 1;
    start_tx(8'hF4);
    wait_end(bd, be, 1, INH + TO + 500);
    check("timeout_cycle", last_end_since, INH + TO + 2);
    check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
`else
    start_tx(8'hF4);
    repeat (INH + 2000) @(negedge clk);
    check("silent_busy", busy, 1'b1);
    check("silent_lines", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    check("silent_no_pulse", {n_done - bd, n_err - be}, 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
